// File: rtl/range_coalesce_pkg.sv
// Shared types for the range coalescer: range tuple, FSM states, default widths
// and the inclusive range length helper.
package range_coalesce_pkg;
  localparam int DATA_WIDTH          = 16;
  localparam int BANK_ADDR_WIDTH     = 8;
  localparam int DEF_COUNT_WIDTH     = DATA_WIDTH + 8;
  localparam int DEF_RANGE_CNT_WIDTH = BANK_ADDR_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] first;
    logic [DATA_WIDTH-1:0] second;
  } tuple_pair_t;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_RUN   = 2'd1,
    CS_FLUSH = 2'd2,
    CS_DONE  = 2'd3
  } coalesce_state_t;

  // One bit wider than the data so a full-span range does not wrap.
  function automatic logic [DATA_WIDTH:0] range_len(input tuple_pair_t r);
    return {1'b0, r.second} - {1'b0, r.first} + {{DATA_WIDTH{1'b0}}, 1'b1};
  endfunction
endpackage

// File: rtl/range_coalesce_if.sv
// Input beat stream, output beat stream and result signals of range_coalesce.
interface range_coalesce_if
  import range_coalesce_pkg::*;
#(
  parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH,
  parameter int RANGE_CNT_WIDTH = DEF_RANGE_CNT_WIDTH
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_lane_valid;
  tuple_pair_t                in_even;
  tuple_pair_t                in_odd;
  logic                       in_last;
  logic [1:0]                 out_valid;
  logic                       out_ready;
  tuple_pair_t                out_even;
  tuple_pair_t                out_odd;
  logic [COUNT_WIDTH-1:0]     total_out;
  logic [RANGE_CNT_WIDTH-1:0] range_count_out;
  logic                       done_out;
  logic                       order_err_out;

  modport master (
    output in_valid, in_lane_valid, in_even, in_odd, in_last, out_ready,
    input  in_ready, out_valid, out_even, out_odd, total_out, range_count_out,
           done_out, order_err_out
  );

  modport slave (
    input  in_valid, in_lane_valid, in_even, in_odd, in_last, out_ready,
    output in_ready, out_valid, out_even, out_odd, total_out, range_count_out,
           done_out, order_err_out
  );
endinterface

// File: rtl/range_coalesce_merge_lane.sv
// One combinational merge step: folds a single candidate range into the open
// range, reporting the range it closes when the candidate is disjoint.
module range_merge_lane
  import range_coalesce_pkg::*;
(
  input  tuple_pair_t i_cur,
  input  logic        i_cur_open,
  input  tuple_pair_t i_r,
  input  logic        i_r_live,
  output tuple_pair_t o_cur,
  output logic        o_cur_open,
  output tuple_pair_t o_closed,
  output logic        o_closed_valid
);
  logic [DATA_WIDTH:0] w_hi_p1;

  assign w_hi_p1 = {1'b0, i_cur.second} + {{DATA_WIDTH{1'b0}}, 1'b1};

  // Drop / open / merge (adjacent counts) / close-and-reopen decision.
  always_comb begin
    o_cur          = i_cur;
    o_cur_open     = i_cur_open;
    o_closed       = '0;
    o_closed_valid = 1'b0;
    if (!i_r_live || (i_r.first > i_r.second)) begin
      o_cur      = i_cur;
      o_cur_open = i_cur_open;
    end else if (!i_cur_open) begin
      o_cur      = i_r;
      o_cur_open = 1'b1;
    end else if ({1'b0, i_r.first} <= w_hi_p1) begin
      if (i_r.second > i_cur.second) begin
        o_cur.second = i_r.second;
      end else begin
        o_cur.second = i_cur.second;
      end
    end else begin
      o_closed       = i_cur;
      o_closed_valid = 1'b1;
      o_cur          = i_r;
      o_cur_open     = 1'b1;
    end
  end
endmodule

// File: rtl/range_coalesce.sv
// Coalesces a sorted two-lane range stream into merged ranges, emitting them
// through one output register and accumulating total covered IDs.
module range_coalesce
  import range_coalesce_pkg::*;
#(
  parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH,
  parameter int RANGE_CNT_WIDTH = DEF_RANGE_CNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  range_coalesce_if.slave  bus
);
  coalesce_state_t            r_state, w_state_nxt;
  tuple_pair_t                r_cur, w_cur_nxt;
  logic                       r_cur_open, w_open_nxt;
  logic [DATA_WIDTH-1:0]      r_last_first;
  logic [1:0]                 r_out_valid;
  tuple_pair_t                r_out_even, r_out_odd;
  logic [COUNT_WIDTH-1:0]     r_total;
  logic [RANGE_CNT_WIDTH-1:0] r_range_cnt;
  logic                       r_done, w_done_nxt;
  logic                       r_order_err;

  logic                       w_out_free, w_in_ready, w_accept;
  tuple_pair_t                w_mid_cur, w_new_cur, w_c0, w_c1;
  logic                       w_mid_open, w_new_open, w_c0_v, w_c1_v;
  logic [DATA_WIDTH-1:0]      w_first_mid, w_first_nxt;
  logic                       w_bad0, w_bad1;
  logic [COUNT_WIDTH-1:0]     w_len0, w_len1, w_len_cur;
  logic [1:0]                 w_pk_valid;
  tuple_pair_t                w_pk_even, w_pk_odd;
  logic [COUNT_WIDTH-1:0]     w_pk_len;
  logic [RANGE_CNT_WIDTH-1:0] w_pk_cnt;
  logic                       w_load;
  logic [1:0]                 w_ld_valid;
  tuple_pair_t                w_ld_even, w_ld_odd;
  logic [COUNT_WIDTH-1:0]     w_ld_len;
  logic [RANGE_CNT_WIDTH-1:0] w_ld_cnt;

  assign w_out_free = (r_out_valid == 2'b00) || bus.out_ready;
  assign w_in_ready = ((r_state == CS_IDLE) || (r_state == CS_RUN)) && w_out_free;
  assign w_accept   = bus.in_valid && w_in_ready;

  range_merge_lane u_lane_even (
    .i_cur(r_cur), .i_cur_open(r_cur_open), .i_r(bus.in_even), .i_r_live(bus.in_lane_valid[0]),
    .o_cur(w_mid_cur), .o_cur_open(w_mid_open), .o_closed(w_c0), .o_closed_valid(w_c0_v)
  );

  range_merge_lane u_lane_odd (
    .i_cur(w_mid_cur), .i_cur_open(w_mid_open), .i_r(bus.in_odd), .i_r_live(bus.in_lane_valid[1]),
    .o_cur(w_new_cur), .o_cur_open(w_new_open), .o_closed(w_c1), .o_closed_valid(w_c1_v)
  );

  // Ordering check chains through the live lanes like the merge does.
  assign w_first_mid = bus.in_lane_valid[0] ? bus.in_even.first : r_last_first;
  assign w_first_nxt = bus.in_lane_valid[1] ? bus.in_odd.first : w_first_mid;
  assign w_bad0      = bus.in_lane_valid[0] && (bus.in_even.first < r_last_first);
  assign w_bad1      = bus.in_lane_valid[1] && (bus.in_odd.first < w_first_mid);

  assign w_len0    = COUNT_WIDTH'(range_len(w_c0));
  assign w_len1    = COUNT_WIDTH'(range_len(w_c1));
  assign w_len_cur = COUNT_WIDTH'(range_len(r_cur));

  // Pack closed ranges so a single close always lands in lane 0.
  always_comb begin
    w_pk_valid = 2'b00;
    w_pk_even  = '0;
    w_pk_odd   = '0;
    w_pk_len   = '0;
    w_pk_cnt   = '0;
    case ({w_c1_v, w_c0_v})
      2'b11: begin
        w_pk_valid = 2'b11;
        w_pk_even  = w_c0;
        w_pk_odd   = w_c1;
        w_pk_len   = w_len0 + w_len1;
        w_pk_cnt   = RANGE_CNT_WIDTH'(2);
      end
      2'b01: begin
        w_pk_valid = 2'b01;
        w_pk_even  = w_c0;
        w_pk_len   = w_len0;
        w_pk_cnt   = RANGE_CNT_WIDTH'(1);
      end
      2'b10: begin
        w_pk_valid = 2'b01;
        w_pk_even  = w_c1;
        w_pk_len   = w_len1;
        w_pk_cnt   = RANGE_CNT_WIDTH'(1);
      end
      default: begin
        w_pk_valid = 2'b00;
      end
    endcase
  end

  // FSM next state plus the output-register load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_open_nxt  = r_cur_open;
    w_done_nxt  = r_done;
    w_load      = 1'b0;
    w_ld_valid  = 2'b00;
    w_ld_even   = '0;
    w_ld_odd    = '0;
    w_ld_len    = '0;
    w_ld_cnt    = '0;
    case (r_state)
      CS_IDLE, CS_RUN: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_ld_valid  = w_pk_valid;
          w_ld_even   = w_pk_even;
          w_ld_odd    = w_pk_odd;
          w_ld_len    = w_pk_len;
          w_ld_cnt    = w_pk_cnt;
          w_cur_nxt   = w_new_cur;
          w_open_nxt  = w_new_open;
          w_state_nxt = bus.in_last ? CS_FLUSH : CS_RUN;
        end else begin
          w_load = 1'b0;
        end
      end
      CS_FLUSH: begin
        if (w_out_free) begin
          w_load = 1'b1;
          if (r_cur_open) begin
            w_ld_valid = 2'b01;
            w_ld_even  = r_cur;
            w_ld_len   = w_len_cur;
            w_ld_cnt   = RANGE_CNT_WIDTH'(1);
            w_open_nxt = 1'b0;
          end else begin
            w_state_nxt = CS_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_load = 1'b0;
        end
      end
      CS_DONE: begin
        w_state_nxt = CS_DONE;
      end
      default: begin
        w_state_nxt = CS_IDLE;
      end
    endcase
  end

  // State, open range, output stage and accumulators.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= CS_IDLE;
      r_cur        <= '0;
      r_cur_open   <= 1'b0;
      r_last_first <= '0;
      r_out_valid  <= 2'b00;
      r_out_even   <= '0;
      r_out_odd    <= '0;
      r_total      <= '0;
      r_range_cnt  <= '0;
      r_done       <= 1'b0;
      r_order_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_cur_open <= w_open_nxt;
      r_done     <= w_done_nxt;
      if (w_accept) begin
        r_last_first <= w_first_nxt;
        r_order_err  <= r_order_err | w_bad0 | w_bad1;
      end
      if (w_load) begin
        r_out_valid <= w_ld_valid;
        r_out_even  <= w_ld_even;
        r_out_odd   <= w_ld_odd;
        r_total     <= r_total + w_ld_len;
        r_range_cnt <= r_range_cnt + w_ld_cnt;
      end else if (bus.out_ready) begin
        r_out_valid <= 2'b00;
      end
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_even        = r_out_even;
  assign bus.out_odd         = r_out_odd;
  assign bus.total_out       = r_total;
  assign bus.range_count_out = r_range_cnt;
  assign bus.done_out        = r_done;
  assign bus.order_err_out   = r_order_err;
endmodule

// File: tb/tb_range_coalesce.sv
// Directed bench for range_coalesce with hand-computed expected values.
module tb_range_coalesce;
  import range_coalesce_pkg::*;

  logic clock;
  logic reset;
  int   vecs;
  int   errs;

  range_coalesce_if bus ();

  range_coalesce dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic tuple_pair_t mk(input int lo, input int hi);
    tuple_pair_t t;
    t.first  = lo[DATA_WIDTH-1:0];
    t.second = hi[DATA_WIDTH-1:0];
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid      = 1'b0;
    bus.in_lane_valid = 2'b00;
    bus.in_last       = 1'b0;
    bus.out_ready     = 1'b1;
    reset             = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [1:0] lv, input int elo, input int ehi,
                      input int olo, input int ohi, input logic last);
    int n;
    bus.in_valid      = 1'b1;
    bus.in_lane_valid = lv;
    bus.in_even       = mk(elo, ehi);
    bus.in_odd        = mk(olo, ohi);
    bus.in_last       = last;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", {63'd0, bus.in_ready}, 64'd1);
    step();
    bus.in_valid      = 1'b0;
    bus.in_lane_valid = 2'b00;
    bus.in_last       = 1'b0;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_lane_valid = 2'b00;
    bus.in_even = '0;
    bus.in_odd = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    reset = 1'b0;
    step();
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {62'd0, bus.out_valid}, 64'd0);
    chk("rst_out_even", {32'd0, bus.out_even}, 64'd0);
    chk("rst_out_odd", {32'd0, bus.out_odd}, 64'd0);
    chk("rst_total", {40'd0, bus.total_out}, 64'd0);
    chk("rst_count", {55'd0, bus.range_count_out}, 64'd0);
    chk("rst_done", {63'd0, bus.done_out}, 64'd0);
    chk("rst_err", {63'd0, bus.order_err_out}, 64'd0);
    do_reset();

    // Two disjoint ranges in one final beat
    send(2'b11, 3, 5, 10, 14, 1'b1);
    chk("t1_valid", {62'd0, bus.out_valid}, 64'd1);
    chk("t1_even", {32'd0, bus.out_even}, {32'd0, 16'd3, 16'd5});
    chk("t1_total_a", {40'd0, bus.total_out}, 64'd3);
    chk("t1_in_ready_flush", {63'd0, bus.in_ready}, 64'd0);
    step();
    chk("t1_flush_valid", {62'd0, bus.out_valid}, 64'd1);
    chk("t1_flush_even", {32'd0, bus.out_even}, {32'd0, 16'd10, 16'd14});
    chk("t1_total", {40'd0, bus.total_out}, 64'd8);
    chk("t1_count", {55'd0, bus.range_count_out}, 64'd2);
    chk("t1_done_early", {63'd0, bus.done_out}, 64'd0);
    step();
    chk("t1_done", {63'd0, bus.done_out}, 64'd1);
    chk("t1_idle_valid", {62'd0, bus.out_valid}, 64'd0);

    // Overlap and adjacency collapse into one range
    do_reset();
    send(2'b11, 10, 14, 12, 18, 1'b0);
    chk("t2_no_out_a", {62'd0, bus.out_valid}, 64'd0);
    send(2'b11, 16, 20, 21, 22, 1'b1);
    chk("t2_no_out_b", {62'd0, bus.out_valid}, 64'd0);
    step();
    chk("t2_even", {32'd0, bus.out_even}, {32'd0, 16'd10, 16'd22});
    chk("t2_total", {40'd0, bus.total_out}, 64'd13);
    chk("t2_count", {55'd0, bus.range_count_out}, 64'd1);
    step();
    chk("t2_done", {63'd0, bus.done_out}, 64'd1);

    // Inverted range is dropped
    do_reset();
    send(2'b11, 5, 4, 7, 7, 1'b1);
    chk("t3_no_out", {62'd0, bus.out_valid}, 64'd0);
    step();
    chk("t3_even", {32'd0, bus.out_even}, {32'd0, 16'd7, 16'd7});
    chk("t3_total", {40'd0, bus.total_out}, 64'd1);
    chk("t3_err", {63'd0, bus.order_err_out}, 64'd0);
    step();
    chk("t3_done", {63'd0, bus.done_out}, 64'd1);

    // Backpressure during a two-close beat
    do_reset();
    send(2'b01, 1, 2, 0, 0, 1'b0);
    bus.out_ready = 1'b0;
    send(2'b11, 5, 6, 9, 9, 1'b0);
    chk("t4_valid", {62'd0, bus.out_valid}, 64'd3);
    chk("t4_total", {40'd0, bus.total_out}, 64'd4);
    bus.in_valid      = 1'b1;
    bus.in_lane_valid = 2'b01;
    bus.in_even       = mk(11, 11);
    bus.in_last       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", {62'd0, bus.out_valid}, 64'd3);
      chk("t4_hold_even", {32'd0, bus.out_even}, {32'd0, 16'd1, 16'd2});
      chk("t4_hold_odd", {32'd0, bus.out_odd}, {32'd0, 16'd5, 16'd6});
      chk("t4_hold_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("t4_hold_total", {40'd0, bus.total_out}, 64'd4);
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid      = 1'b0;
    bus.in_lane_valid = 2'b00;
    bus.in_last       = 1'b0;
    chk("t4_rel_even", {32'd0, bus.out_even}, {32'd0, 16'd9, 16'd9});
    chk("t4_rel_total", {40'd0, bus.total_out}, 64'd5);
    chk("t4_rel_count", {55'd0, bus.range_count_out}, 64'd3);
    step();
    chk("t4_flush_even", {32'd0, bus.out_even}, {32'd0, 16'd11, 16'd11});
    chk("t4_total", {40'd0, bus.total_out}, 64'd6);
    chk("t4_count", {55'd0, bus.range_count_out}, 64'd4);

    // Descending first is flagged and sticky
    do_reset();
    send(2'b01, 9, 9, 0, 0, 1'b0);
    chk("t5_err_clear", {63'd0, bus.order_err_out}, 64'd0);
    send(2'b01, 2, 3, 0, 0, 1'b0);
    chk("t5_err_set", {63'd0, bus.order_err_out}, 64'd1);
    send(2'b01, 20, 20, 0, 0, 1'b1);
    chk("t5_err_sticky", {63'd0, bus.order_err_out}, 64'd1);
    chk("t5_merged", {32'd0, bus.out_even}, {32'd0, 16'd9, 16'd9});
    do_reset();
    chk("t5_err_reset", {63'd0, bus.order_err_out}, 64'd0);

    // Reset mid-stream then a fresh stream
    send(2'b01, 1, 4, 0, 0, 1'b0);
    send(2'b01, 10, 12, 0, 0, 1'b0);
    chk("t6_pre_total", {40'd0, bus.total_out}, 64'd4);
    reset = 1'b0;
    #1;
    chk("t6_rst_total", {40'd0, bus.total_out}, 64'd0);
    chk("t6_rst_valid", {62'd0, bus.out_valid}, 64'd0);
    chk("t6_rst_count", {55'd0, bus.range_count_out}, 64'd0);
    step();
    reset = 1'b1;
    step();
    send(2'b11, 0, 0, 1, 1, 1'b1);
    step();
    chk("t6_even", {32'd0, bus.out_even}, {32'd0, 16'd0, 16'd1});
    chk("t6_total", {40'd0, bus.total_out}, 64'd2);
    chk("t6_count", {55'd0, bus.range_count_out}, 64'd1);
    step();
    chk("t6_done", {63'd0, bus.done_out}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
